// File: rtl/hidden_layer.sv
`default_nettype none
// ============================================================================
//  Module      : hidden_layer
//  Description : Two-layer fixed-point MLP core (10 inputs -> 5 hidden ->
//                3 outputs). One serial signed MAC evaluates one weight per
//                cycle from an internal, loadable 65-entry weight memory.
//
//  Ports
//    clk          rising-edge clock
//    rst_n        asynchronous active-low reset
//    i_we         weight-load request (acted on only in IDLE)
//    i_in         run enable: start / continue inference
//    i_in_val     10 x 10-bit unsigned features, feature i at [i*10 +: 10]
//                 (feature 0 doubles as weight write data while loading)
//    o_out_val    5 x 10-bit hidden activations, neuron j at [j*10 +: 10]
//    o_out_val1   3 x 10-bit output activations, neuron k at [k*10 +: 10]
//    o_state      current FSM state code
//    o_address    current weight-memory address
//
//  Revision    : 1.0  initial release
// ============================================================================
module hidden_layer #(
    parameter int                 FRAC  = 0,
    parameter logic signed [9:0]  WINIT = 10'sd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_we,
    input  logic         i_in,
    input  logic [99:0]  i_in_val,
    output logic [49:0]  o_out_val,
    output logic [29:0]  o_out_val1,
    output logic [3:0]   o_state,
    output logic [6:0]   o_address
);

    localparam logic [6:0] c_ADDR_HLAST = 7'd49;   // last hidden-layer weight
    localparam logic [6:0] c_ADDR_OLAST = 7'd64;   // last output-layer weight

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LOAD = 4'd1,
        S_HMAC = 4'd2,
        S_OMAC = 4'd3,
        S_DONE = 4'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [6:0]          r_addr;
    logic [3:0]          r_sub;     // input index within the current neuron
    logic [2:0]          r_neu;     // neuron index within the current layer
    logic signed [25:0]  r_acc;
    logic signed [9:0]   r_w    [0:64];
    logic [9:0]          r_out  [0:4];
    logic [9:0]          r_out1 [0:2];

    // ------------------------------------------------------------------
    // Next-state / control wires
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [6:0]          w_addr_nxt;
    logic [3:0]          w_sub_nxt;
    logic [2:0]          w_neu_nxt;
    logic                w_acc_clr;
    logic                w_mac_en;
    logic                w_wr_en;
    logic                w_h_wr;
    logic                w_o_wr;

    // Datapath wires
    logic [9:0]          w_in [0:9];
    logic [9:0]          w_x;
    logic signed [9:0]   w_w_sel;
    logic signed [20:0]  w_prod;
    logic signed [25:0]  w_acc_sum;
    logic [9:0]          w_act;

    // ------------------------------------------------------------------
    // Unpack the flat feature bus and pack the activation arrays
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_in_unpack
            assign w_in[gi] = i_in_val[gi*10 +: 10];
        end
        for (gi = 0; gi < 5; gi++) begin : g_out_pack
            assign o_out_val[gi*10 +: 10] = r_out[gi];
        end
        for (gi = 0; gi < 3; gi++) begin : g_out1_pack
            assign o_out_val1[gi*10 +: 10] = r_out1[gi];
        end
    endgenerate

    assign o_state   = r_state;
    assign o_address = r_addr;

    // ------------------------------------------------------------------
    // Activation: scale, ReLU, saturate to 10 unsigned bits
    // ------------------------------------------------------------------
    function automatic logic [9:0] act(input logic signed [25:0] a);
        logic signed [25:0] y;
        y = a >>> FRAC;
        if (y[25])
            act = 10'd0;
        else if (y > 26'sd1023)
            act = 10'd1023;
        else
            act = y[9:0];
    endfunction

    // ------------------------------------------------------------------
    // MAC datapath (combinational part)
    // ------------------------------------------------------------------
    always_comb begin
        w_x = 10'd0;
        if (r_state == S_OMAC)
            w_x = r_out[r_sub[2:0]];
        else
            w_x = w_in[r_sub];
    end

    assign w_w_sel   = r_w[r_addr];
    // Features are unsigned: a zero MSB keeps them positive in the signed product.
    assign w_prod    = $signed({1'b0, w_x}) * w_w_sel;
    assign w_acc_sum = r_acc + {{5{w_prod[20]}}, w_prod};
    assign w_act     = act(w_acc_sum);

    // ------------------------------------------------------------------
    // FSM next-state and control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_sub_nxt   = r_sub;
        w_neu_nxt   = r_neu;
        w_acc_clr   = 1'b0;
        w_mac_en    = 1'b0;
        w_wr_en     = 1'b0;
        w_h_wr      = 1'b0;
        w_o_wr      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_we) begin
                    w_state_nxt = S_LOAD;
                    w_addr_nxt  = 7'd0;
                end else if (i_in) begin
                    w_state_nxt = S_HMAC;
                    w_addr_nxt  = 7'd0;
                    w_sub_nxt   = 4'd0;
                    w_neu_nxt   = 3'd0;
                    w_acc_clr   = 1'b1;
                end
            end

            S_LOAD: begin
                // The current cycle always writes; dropping WE ends the load
                // after this final word.
                w_wr_en = 1'b1;
                if ((r_addr == c_ADDR_OLAST) || !i_we) begin
                    w_state_nxt = S_IDLE;
                    w_addr_nxt  = 7'd0;
                end else begin
                    w_addr_nxt  = r_addr + 7'd1;
                end
            end

            S_HMAC: begin
                w_mac_en   = 1'b1;
                w_addr_nxt = r_addr + 7'd1;
                if (r_sub == 4'd9) begin
                    w_h_wr    = 1'b1;
                    w_acc_clr = 1'b1;
                    w_sub_nxt = 4'd0;
                    w_neu_nxt = r_neu + 3'd1;
                end else begin
                    w_sub_nxt = r_sub + 4'd1;
                end
                if (r_addr == c_ADDR_HLAST) begin
                    w_state_nxt = S_OMAC;
                    w_neu_nxt   = 3'd0;
                end
            end

            S_OMAC: begin
                w_mac_en = 1'b1;
                if (r_sub == 4'd4) begin
                    w_o_wr    = 1'b1;
                    w_acc_clr = 1'b1;
                    w_sub_nxt = 4'd0;
                    w_neu_nxt = r_neu + 3'd1;
                end else begin
                    w_sub_nxt = r_sub + 4'd1;
                end
                if (r_addr == c_ADDR_OLAST)
                    w_state_nxt = S_DONE;
                else
                    w_addr_nxt  = r_addr + 7'd1;
            end

            S_DONE: begin
                w_addr_nxt = 7'd0;
                if (i_in) begin
                    w_state_nxt = S_HMAC;
                    w_sub_nxt   = 4'd0;
                    w_neu_nxt   = 3'd0;
                    w_acc_clr   = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_addr_nxt  = 7'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state and sequencing counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= 7'd0;
            r_sub   <= 4'd0;
            r_neu   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_sub   <= w_sub_nxt;
            r_neu   <= w_neu_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator and activation registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 26'sd0;
            for (int j = 0; j < 5; j++) r_out[j]  <= 10'd0;
            for (int k = 0; k < 3; k++) r_out1[k] <= 10'd0;
        end else begin
            if (w_acc_clr)
                r_acc <= 26'sd0;
            else if (w_mac_en)
                r_acc <= w_acc_sum;
            if (w_h_wr)
                r_out[r_neu] <= w_act;
            if (w_o_wr)
                r_out1[r_neu[1:0]] <= w_act;
        end
    end

    // ------------------------------------------------------------------
    // Weight memory
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < 65; a++) r_w[a] <= WINIT;
        end else if (w_wr_en && (r_addr <= c_ADDR_OLAST)) begin
            r_w[r_addr] <= $signed(i_in_val[9:0]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hidden_layer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hidden_layer
//  Description : Self-checking bench for hidden_layer. A reference model of
//                the MLP pushes expected activations to a scoreboard queue
//                when a pass is launched; they are popped and compared when
//                the DUT reaches DONE.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hidden_layer;

    logic         clk;
    logic         rst_n;
    logic         i_we;
    logic         i_in;
    logic [99:0]  i_in_val;
    logic [49:0]  o_out_val;
    logic [29:0]  o_out_val1;
    logic [3:0]   o_state;
    logic [6:0]   o_address;

    hidden_layer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (i_we),
        .i_in       (i_in),
        .i_in_val   (i_in_val),
        .o_out_val  (o_out_val),
        .o_out_val1 (o_out_val1),
        .o_state    (o_state),
        .o_address  (o_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int h [5];
        int o [3];
    } exp_t;

    exp_t sb [$];
    int   m_w  [65];
    int   m_x  [10];
    int   ld_val [65];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int act(input int a);
        if (a < 0)    return 0;
        if (a > 1023) return 1023;
        return a;
    endfunction

    function automatic exp_t model();
        exp_t e;
        for (int j = 0; j < 5; j++) begin
            int acc = 0;
            for (int i = 0; i < 10; i++) acc += m_x[i] * m_w[j*10+i];
            e.h[j] = act(acc);
        end
        for (int k = 0; k < 3; k++) begin
            int acc = 0;
            for (int j = 0; j < 5; j++) acc += e.h[j] * m_w[50+k*5+j];
            e.o[k] = act(acc);
        end
        return e;
    endfunction

    function automatic int sext10(input int v);
        logic [9:0] b;
        b = v[9:0];
        return b[9] ? int'(b) - 1024 : int'(b);
    endfunction

    task automatic set_inputs();
        for (int i = 0; i < 10; i++) i_in_val[i*10 +: 10] = m_x[i][9:0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int a = 0; a < 65; a++) m_w[a] = 1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Load words 0..n-1 from ld_val; WE falls on the last word.
    task automatic load(input int n, input string tag);
        @(negedge clk);
        i_we = 1'b1;
        i_in_val[9:0] = ld_val[0][9:0];
        @(posedge clk);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            i_in_val[9:0] = ld_val[c][9:0];
            i_we = (c + 1 < n);
            m_w[c] = sext10(ld_val[c]);
            @(posedge clk);
        end
        @(negedge clk);
        i_we = 1'b0;
        chk({tag, " state_idle"}, 32'(o_state), 32'd0);
        chk({tag, " addr0"},      32'(o_address), 32'd0);
    endtask

    // Wait for DONE, check latency, pop the scoreboard and compare.
    task automatic wait_done(input string tag, input int exp_cyc, input int drop_at);
        int  cyc  = 0;
        bit  seen = 1'b0;
        exp_t e;
        while (!seen && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == drop_at) i_in = 1'b0;
            if (o_state == 4'd4) seen = 1'b1;
        end
        chk({tag, " done"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
        if (sb.size() == 0) begin
            chk({tag, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            for (int j = 0; j < 5; j++)
                chk($sformatf("%s h%0d", tag, j), 32'(o_out_val[j*10 +: 10]), 32'(e.h[j]));
            for (int k = 0; k < 3; k++)
                chk($sformatf("%s o%0d", tag, k), 32'(o_out_val1[k*10 +: 10]), 32'(e.o[k]));
        end
    endtask

    task automatic run_pass(input string tag);
        @(negedge clk);
        set_inputs();
        sb.push_back(model());
        i_in = 1'b1;
        wait_done(tag, 66, 1);
        @(negedge clk);
        chk({tag, " back_idle"}, 32'(o_state), 32'd0);
    endtask

    initial begin
        exp_t e;
        rst_n    = 1'b0;
        i_we     = 1'b0;
        i_in     = 1'b0;
        i_in_val = '0;
        for (int a = 0; a < 65; a++) m_w[a] = 1;
        #12;
        chk("rst state",  32'(o_state), 32'd0);
        chk("rst addr",   32'(o_address), 32'd0);
        chk("rst outval", 32'(o_out_val), 32'd0);
        chk("rst outval1",32'(o_out_val1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default weights, unit inputs: 10 / 50
        for (int i = 0; i < 10; i++) m_x[i] = 1;
        e = model();
        chk("model h", 32'(e.h[0]), 32'd10);
        chk("model o", 32'(e.o[0]), 32'd50);
        run_pass("ones");

        // Saturation
        for (int i = 0; i < 10; i++) m_x[i] = 1023;
        run_pass("sat");

        // All weights -1 -> ReLU clamps to zero
        for (int a = 0; a < 65; a++) ld_val[a] = 10'h3FF;
        load(65, "ld_neg");
        for (int i = 0; i < 10; i++) m_x[i] = 5;
        run_pass("neg");

        // Partial load of only W[0]
        do_reset();
        ld_val[0] = 3;
        load(1, "ld_w0");
        for (int i = 0; i < 10; i++) m_x[i] = 1;
        run_pass("w0");

        // Random weights / inputs, full and partial loads
        for (int t = 0; t < 3; t++) begin
            for (int a = 0; a < 65; a++) ld_val[a] = int'($urandom_range(0, 15)) - 8;
            load((t == 2) ? 23 : 65, $sformatf("ld_rnd%0d", t));
            for (int i = 0; i < 10; i++) m_x[i] = int'($urandom_range(0, 200));
            run_pass($sformatf("rnd%0d", t));
        end

        // Free-running: three passes with In held, then In dropped mid-pass
        do_reset();
        for (int i = 0; i < 10; i++) m_x[i] = 2;
        @(negedge clk);
        set_inputs();
        i_in = 1'b1;
        for (int p = 0; p < 3; p++) sb.push_back(model());
        wait_done("free0", 66, -1);
        wait_done("free1", 66, -1);
        wait_done("free2", 66, 30);
        @(negedge clk);
        chk("free back_idle", 32'(o_state), 32'd0);

        // Async reset in the middle of HMAC
        @(negedge clk);
        i_in = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            @(negedge clk);
            i_in = 1'b0;
            if (o_state == 4'd2 && o_address == 7'd23) break;
        end
        chk("mid addr23", 32'(o_address), 32'd23);
        rst_n = 1'b0;
        #1;
        chk("mid rst state",  32'(o_state), 32'd0);
        chk("mid rst addr",   32'(o_address), 32'd0);
        chk("mid rst outval", 32'(o_out_val), 32'd0);
        chk("mid rst outval1",32'(o_out_val1), 32'd0);
        for (int a = 0; a < 65; a++) m_w[a] = 1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) m_x[i] = 1;
        run_pass("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
